// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit
// per clock). Produces six packed BCD digits for the seven-segment display
// path plus an overflow flag for inputs above 999999.
//
// Build option: define BIN2BCD_SATURATE_EN to clamp the displayed value to
// 999999 on overflow. Without it the lower six digits (value mod 1000000)
// are shown. Conversion timing is the same in both builds.

module bin2bcd_seq #(
  parameter int IN_WIDTH = 20  // legal range 4..20
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [IN_WIDTH-1:0] i_bin,
  output logic                o_busy,
  output logic                o_valid,
  output logic [23:0]         o_bcd,
  output logic                o_overflow
);

  // Seven BCD digits: six visible digits plus one overflow digit, enough for
  // the largest 20-bit input (1048575).
  localparam int ACC_W = 28;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IN_WIDTH-1:0] bin_sr;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [23:0]         bcd_q;
  logic                ovf_q;

  // FSM control strobes
  logic accept;     // start accepted this edge (IDLE or DONE)
  logic shift_en;   // perform one double-dabble step this edge
  logic last_step;  // this edge performs the final step

  // Datapath combinational values
  logic [ACC_W-1:0]          acc_adj;
  logic [ACC_W+IN_WIDTH-1:0] shifted;
  logic [ACC_W-1:0]          acc_next;
  logic [IN_WIDTH-1:0]       bin_next;
  logic                      ovf_next;
  logic [23:0]               bcd_next;

  // Add 3 to each digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int k = 0; k < ACC_W / 4; k++) begin
      if (a[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together on the edge; blocking here would create order-dependent
  // simulation and mismatch the synthesized flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and control strobes.
  // NOTE: every signal written here gets a default first, otherwise a missed
  // branch would infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    last_step  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // i_start is deliberately ignored here: no queueing of requests.
        shift_en = 1'b1;
        if (cnt == LAST_CNT) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back: a start in DONE re-enters SHIFT directly.
        if (i_start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // One double-dabble step: adjust digits, then shift {acc, bin} left by one.
  // The top accumulator bit falls off; it is always zero for legal widths.
  always_comb begin
    acc_adj  = add3_digits(acc);
    shifted  = {acc_adj, bin_sr} << 1;
    acc_next = shifted[ACC_W+IN_WIDTH-1:IN_WIDTH];
    bin_next = shifted[IN_WIDTH-1:0];
  end

  // Final result formatting from the accumulator as it will be after the
  // last step. The seventh digit nonzero means the input exceeded 999999.
  always_comb begin
    ovf_next = (acc_next[27:24] != 4'd0);
`ifdef BIN2BCD_SATURATE_EN
    bcd_next = ovf_next ? 24'h999999 : acc_next[23:0];
`else
    bcd_next = acc_next[23:0];
`endif
  end

  // Working registers: binary shift register, BCD accumulator, bit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_sr <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      bin_sr <= i_bin;
      acc    <= '0;
      cnt    <= '0;
    end else if (shift_en) begin
      bin_sr <= bin_next;
      acc    <= acc_next;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers: updated only on the final step so the outputs never
  // show partial results and hold across idle periods.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bcd_q <= 24'h000000;
      ovf_q <= 1'b0;
    end else if (last_step) begin
      bcd_q <= bcd_next;
      ovf_q <= ovf_next;
    end
  end

  // Status outputs decode directly from the state register (glitch-free).
  assign o_busy     = (state == ST_SHIFT);
  assign o_valid    = (state == ST_DONE);
  assign o_bcd      = bcd_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: constant vector table, hand-written multi-cycle
// sequences (ignored start, back-to-back, reset abort, async clear) and
// random values checked against an arithmetic decimal model.

module tb_bin2bcd_seq;

  localparam int W = 20;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         valid;
  logic [23:0]  bcd;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  bin2bcd_seq #(.IN_WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_bin     (bin),
    .o_busy    (busy),
    .o_valid   (valid),
    .o_bcd     (bcd),
    .o_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic [23:0]  bcd;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; settle 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal model: plain arithmetic on the integer value.
  function automatic logic [24:0] model(input int unsigned v);
    int unsigned r;
    logic [23:0] d;
    logic        o;
    o = (v > 999999);
    r = v % 1000000;
`ifdef BIN2BCD_SATURATE_EN
    if (o) r = 999999;
`endif
    for (int k = 0; k < 6; k++) begin
      d[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {o, d};
  endfunction

  // Full conversion with timing checks; i_bin is scrambled during SHIFT.
  task automatic convert(input string name, input logic [W-1:0] v,
                         input logic [23:0] exp_bcd, input logic exp_ovf);
    int n;
    bin   = v;
    start = 1'b1;
    step();
    start = 1'b0;
    bin   = W'($urandom);
    n = 0;
    while (busy && n < 100) begin
      if (n == 3) bin = W'($urandom);
      n++;
      step();
    end
    check({name, " busy_cycles"}, 32'(n), 32'(W));
    check({name, " valid"}, 32'(valid), 32'd1);
    check({name, " bcd"}, 32'(bcd), 32'(exp_bcd));
    check({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
    step();
    check({name, " valid_drop"}, 32'(valid), 32'd0);
    check({name, " bcd_hold"}, 32'(bcd), 32'(exp_bcd));
  endtask

  vec_t vecs[$];

  initial begin
    logic [24:0] m;
    int          n_valid;
    int          n;
    logic [23:0] seen_bcd;

    // Hand-computed expected values.
    vecs.push_back('{20'd123456, 24'h123456, 1'b0});
    vecs.push_back('{20'd0,      24'h000000, 1'b0});
    vecs.push_back('{20'd999999, 24'h999999, 1'b0});
    vecs.push_back('{20'd1,      24'h000001, 1'b0});
    vecs.push_back('{20'd10,     24'h000010, 1'b0});
    vecs.push_back('{20'd65535,  24'h065535, 1'b0});
`ifdef BIN2BCD_SATURATE_EN
    vecs.push_back('{20'd1000000, 24'h999999, 1'b1});
    vecs.push_back('{20'd1048575, 24'h999999, 1'b1});
`else
    vecs.push_back('{20'd1000000, 24'h000000, 1'b1});
    vecs.push_back('{20'd1048575, 24'h048575, 1'b1});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("reset bcd", 32'(bcd), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      convert($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
      repeat (2) step();
    end

    // Asynchronous reset mid-cycle with nonzero outputs held.
    check("pre_async bcd_nonzero", 32'(bcd != 24'h0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async bcd", 32'(bcd), 32'h0);
    check("async ovf", 32'(ovf), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    step();

    // Start while busy is ignored; single valid with 42.
    bin   = 20'd42;
    start = 1'b1;
    step();
    start = 1'b0;
    n_valid  = 0;
    seen_bcd = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        bin   = 20'd7;
        start = 1'b1;
      end else if (c == 6) begin
        start = 1'b0;
        bin   = 20'd999;
      end
      if (valid) begin
        n_valid++;
        seen_bcd = bcd;
      end
      step();
    end
    check("ignore n_valid", 32'(n_valid), 32'd1);
    check("ignore bcd", 32'(seen_bcd), 32'h000042);
    check("ignore idle", 32'(busy), 32'd0);

    // Back-to-back: start held through DONE, 77 presented in DONE.
    bin   = 20'd500;
    start = 1'b1;
    step();
    bin = 20'd333;
    n = 0;
    while (!valid && n < 100) begin
      n++;
      step();
    end
    check("b2b first_latency", 32'(n), 32'(W));
    check("b2b first_bcd", 32'(bcd), 32'h000500);
    bin = 20'd77;
    step();
    bin = 20'd444;
    check("b2b restart_busy", 32'(busy), 32'd1);
    n = 1;
    while (!valid && n < 100) begin
      n++;
      step();
    end
    start = 1'b0;
    check("b2b period", 32'(n), 32'(W + 1));
    check("b2b second_bcd", 32'(bcd), 32'h000077);
    step();
    check("b2b back_idle", 32'(busy | valid), 32'd0);
    step();

    // Reset abort at busy cycle 10.
    bin   = 20'd654321;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("abort busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    n_valid = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (valid) n_valid++;
    end
    check("abort no_valid", 32'(n_valid), 32'd0);
    check("abort bcd", 32'(bcd), 32'h0);
    convert("abort_redo", 20'd654321, 24'h654321, 1'b0);

    // Random values against the arithmetic model, biased toward the
    // 999999/1000000 boundary on some draws.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] v;
      if (i % 4 == 0) v = W'(999990 + $urandom_range(0, 20));
      else            v = W'($urandom);
      m = model(int'(v));
      convert($sformatf("rand%0d_%0d", i, v), v, m[23:0], m[24]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
